c1571_gcr_stream: RTL

- Read-side GCR sector serializer, directly downstream of the drive track buffer.
- Fetches sector bytes over the buffer's {sector, buff_addr} port and synthesizes headers, checksums, syncs and gaps.
- 4-to-5 GCR encodes the stream and delivers one encoded byte per byte_en tick, with byte_ready and sync_n, to the drive's read shifter/VIA logic.
- Sectors rotate endlessly, as on a spinning disk.

---
 rtl/c1571_gcr_stream.sv | 264 ++++++++++++++++++++++++++
 1 files changed

// File: rtl/c1571_gcr_stream.sv
// Read-side GCR sector serializer: fetches track-buffer bytes, synthesizes
// syncs/headers/checksums/gaps and delivers one GCR byte per byte_en tick.
module c1571_gcr_stream #(
   parameter int unsigned GAP1_LEN = 9,
   parameter int unsigned GAP2_LEN = 8,
   parameter int unsigned SYNC_LEN = 5
) (
   input  logic       clk,
   input  logic       reset_n,
   input  logic       byte_en,
   input  logic       mtr,
   input  logic       busy,
   input  logic [5:0] track,
   input  logic [7:0] id1,
   input  logic [7:0] id2,
   output logic [4:0] buff_sector,
   output logic [7:0] buff_addr,
   input  logic [7:0] buff_dout,
   output logic [7:0] gcr_byte,
   output logic       byte_ready,
   output logic       sync_n,
   output logic [4:0] cur_sector
);

   localparam int unsigned CNT_W = 9;
   localparam int unsigned GRP_W = 7;

   localparam logic [2:0] S_IDLE  = 3'd0;
   localparam logic [2:0] S_SYNC1 = 3'd1;
   localparam logic [2:0] S_HDR   = 3'd2;
   localparam logic [2:0] S_GAP1  = 3'd3;
   localparam logic [2:0] S_SYNC2 = 3'd4;
   localparam logic [2:0] S_DATA  = 3'd5;
   localparam logic [2:0] S_GAP2  = 3'd6;

   localparam logic [CNT_W-1:0] SYNC_LAST = CNT_W'(SYNC_LEN - 1);
   localparam logic [CNT_W-1:0] GAP1_LAST = CNT_W'(GAP1_LEN - 1);
   localparam logic [CNT_W-1:0] GAP2_LAST = CNT_W'(GAP2_LEN - 1);
   localparam logic [GRP_W-1:0] HDR_LAST  = GRP_W'(1);
   localparam logic [GRP_W-1:0] DATA_LAST = GRP_W'(64);

   function automatic logic [4:0] gcr5(input logic [3:0] n);
      logic [4:0] g;
      case (n)
         4'h0: g = 5'h0A;  4'h1: g = 5'h0B;  4'h2: g = 5'h12;  4'h3: g = 5'h13;
         4'h4: g = 5'h0E;  4'h5: g = 5'h0F;  4'h6: g = 5'h16;  4'h7: g = 5'h17;
         4'h8: g = 5'h09;  4'h9: g = 5'h19;  4'hA: g = 5'h1A;  4'hB: g = 5'h1B;
         4'hC: g = 5'h0D;  4'hD: g = 5'h1D;  4'hE: g = 5'h1E;  default: g = 5'h15;
      endcase
      return g;
   endfunction

   function automatic logic [39:0] gcr_enc(input logic [31:0] r);
      logic [39:0] o;
      o = '0;
      for (int i = 0; i < 8; i++) o[39-5*i -: 5] = gcr5(r[31-4*i -: 4]);
      return o;
   endfunction

   function automatic logic [4:0] sec_count(input logic [5:0] t);
      logic [4:0] c;
      if (t >= 6'd1 && t <= 6'd17)       c = 5'd21;
      else if (t >= 6'd18 && t <= 6'd24) c = 5'd19;
      else if (t >= 6'd25 && t <= 6'd30) c = 5'd18;
      else                               c = 5'd17;
      return c;
   endfunction

   function automatic logic is_buf(input logic [8:0] idx);
      return (idx >= 9'd1) && (idx <= 9'd256);
   endfunction

   logic [2:0]       state, state_nx;
   logic [CNT_W-1:0] cnt, cnt_nx;
   logic [GRP_W-1:0] grp, grp_nx;
   logic             fetching, fetching_nx;
   logic [2:0]       fstep, fstep_nx;
   logic [31:0]      raw_grp, raw_grp_nx;
   logic [39:0]      shreg, shreg_nx;
   logic [7:0]       dchk, dchk_nx;
   logic [5:0]       trk_lat, trk_lat_nx;
   logic [4:0]       cur_sector_nx, buff_sector_nx;
   logic [7:0]       buff_addr_nx, gcr_byte_nx;
   logic             byte_ready_nx, sync_n_nx;

   logic [8:0]       idx_addr, idx_cap;
   logic [7:0]       hdr_chk, raw_cap;

   assign idx_addr = {grp, 2'b00} + 9'(fstep);
   assign idx_cap  = {grp, 2'b00} + 9'(fstep) - 9'd2;
   assign hdr_chk  = 8'(cur_sector) ^ 8'(trk_lat) ^ id2 ^ id1;

   // Raw byte for the fetch slot being captured this clk
   always_comb begin
      raw_cap = 8'h00;
      if (state == S_HDR) begin
         case (idx_cap[2:0])
            3'd0:    raw_cap = 8'h08;
            3'd1:    raw_cap = hdr_chk;
            3'd2:    raw_cap = 8'(cur_sector);
            3'd3:    raw_cap = 8'(trk_lat);
            3'd4:    raw_cap = id2;
            3'd5:    raw_cap = id1;
            default: raw_cap = 8'h0F;
         endcase
      end else begin
         if (idx_cap == 9'd0)        raw_cap = 8'h07;
         else if (is_buf(idx_cap))   raw_cap = buff_dout;
         else if (idx_cap == 9'd257) raw_cap = dchk;
         else                        raw_cap = 8'h00;
      end
   end

   // Next-state and datapath
   always_comb begin
      state_nx       = state;
      cnt_nx         = cnt;
      grp_nx         = grp;
      fetching_nx    = fetching;
      fstep_nx       = fstep;
      raw_grp_nx     = raw_grp;
      shreg_nx       = shreg;
      dchk_nx        = dchk;
      trk_lat_nx     = trk_lat;
      cur_sector_nx  = cur_sector;
      buff_sector_nx = cur_sector;
      buff_addr_nx   = buff_addr;
      gcr_byte_nx    = gcr_byte;
      byte_ready_nx  = 1'b0;
      sync_n_nx      = sync_n;

      // Address at steps 0-3, capture at steps 2-5 (buffer has one clk of read latency), encode at 6
      if (fetching) begin
         fstep_nx = fstep + 3'd1;
         if (fstep <= 3'd3 && state == S_DATA && is_buf(idx_addr))
            buff_addr_nx = 8'(idx_addr - 9'd1);
         if (fstep >= 3'd2 && fstep <= 3'd5) begin
            raw_grp_nx = {raw_grp[23:0], raw_cap};
            if (state == S_DATA && is_buf(idx_cap)) dchk_nx = dchk ^ buff_dout;
         end
         if (fstep == 3'd6) begin
            shreg_nx    = gcr_enc(raw_grp);
            fetching_nx = 1'b0;
         end
      end

      if (!mtr || busy) begin
         state_nx    = S_IDLE;
         sync_n_nx   = 1'b1;
         fetching_nx = 1'b0;
      end else if (state == S_IDLE) begin
         state_nx   = S_SYNC1;
         cnt_nx     = '0;
         trk_lat_nx = track;
         if (track != trk_lat) cur_sector_nx = '0;
      end else if (byte_en) begin
         if (track != trk_lat) begin
            // Track moved: this byte is already the first sync of sector 0
            state_nx      = S_SYNC1;
            cnt_nx        = CNT_W'(1);
            cur_sector_nx = '0;
            trk_lat_nx    = track;
            fetching_nx   = 1'b0;
            gcr_byte_nx   = 8'hFF;
            sync_n_nx     = 1'b0;
         end else begin
            case (state)
               S_SYNC1, S_SYNC2: begin
                  gcr_byte_nx = 8'hFF;
                  sync_n_nx   = 1'b0;
                  if (cnt == SYNC_LAST) begin
                     cnt_nx      = '0;
                     grp_nx      = '0;
                     fetching_nx = 1'b1;
                     fstep_nx    = '0;
                     if (state == S_SYNC1) begin
                        state_nx = S_HDR;
                     end else begin
                        state_nx = S_DATA;
                        dchk_nx  = 8'h00;
                     end
                  end else begin
                     cnt_nx = cnt + CNT_W'(1);
                  end
               end
               S_HDR, S_DATA: begin
                  gcr_byte_nx   = shreg[39:32];
                  shreg_nx      = {shreg[31:0], 8'h00};
                  byte_ready_nx = 1'b1;
                  sync_n_nx     = 1'b1;
                  if (cnt == CNT_W'(4)) begin
                     cnt_nx = '0;
                     if (grp == ((state == S_HDR) ? HDR_LAST : DATA_LAST)) begin
                        state_nx = (state == S_HDR) ? S_GAP1 : S_GAP2;
                     end else begin
                        grp_nx      = grp + GRP_W'(1);
                        fetching_nx = 1'b1;
                        fstep_nx    = '0;
                     end
                  end else begin
                     cnt_nx = cnt + CNT_W'(1);
                  end
               end
               S_GAP1, S_GAP2: begin
                  gcr_byte_nx   = 8'h55;
                  byte_ready_nx = 1'b1;
                  sync_n_nx     = 1'b1;
                  if (cnt == ((state == S_GAP1) ? GAP1_LAST : GAP2_LAST)) begin
                     cnt_nx = '0;
                     if (state == S_GAP1) begin
                        state_nx = S_SYNC2;
                     end else begin
                        state_nx   = S_SYNC1;
                        trk_lat_nx = track;
                        if ((cur_sector + 5'd1) >= sec_count(trk_lat)) cur_sector_nx = '0;
                        else                                           cur_sector_nx = cur_sector + 5'd1;
                     end
                  end else begin
                     cnt_nx = cnt + CNT_W'(1);
                  end
               end
               default: state_nx = S_IDLE;
            endcase
         end
      end
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state       <= S_IDLE;
         cnt         <= '0;
         grp         <= '0;
         fetching    <= 1'b0;
         fstep       <= '0;
         raw_grp     <= '0;
         shreg       <= '0;
         dchk        <= '0;
         trk_lat     <= '0;
         cur_sector  <= '0;
         buff_sector <= '0;
         buff_addr   <= '0;
         gcr_byte    <= '0;
         byte_ready  <= 1'b0;
         sync_n      <= 1'b1;
      end else begin
         state       <= state_nx;
         cnt         <= cnt_nx;
         grp         <= grp_nx;
         fetching    <= fetching_nx;
         fstep       <= fstep_nx;
         raw_grp     <= raw_grp_nx;
         shreg       <= shreg_nx;
         dchk        <= dchk_nx;
         trk_lat     <= trk_lat_nx;
         cur_sector  <= cur_sector_nx;
         buff_sector <= buff_sector_nx;
         buff_addr   <= buff_addr_nx;
         gcr_byte    <= gcr_byte_nx;
         byte_ready  <= byte_ready_nx;
         sync_n      <= sync_n_nx;
      end
   end

endmodule
